// File: rtl/gpr_wr_arb.sv
// GPR write-port arbiter: two one-entry holding slots (ALU/PC path A, load path L)
// drained round-robin into a registered write port with a per-grant retire pulse.
module gpr_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int GPRS_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [GPRS_WIDTH-1:0] i_alu_id,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [GPRS_WIDTH-1:0] i_lsu_id,
  input  logic [DATA_WIDTH-1:0] i_lsu_data,
  input  logic                  i_flush,
  output logic                  o_gpr_wr_en,
  output logic [GPRS_WIDTH-1:0] o_gpr_wr_id,
  output logic [DATA_WIDTH-1:0] o_gpr_wr_data,
  output logic                  o_wr_src,
  output logic                  o_commit,
  output logic                  o_busy
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_L = 1'b1
  } src_e;

  // Holding slots
  logic                  r_a_full;
  logic [GPRS_WIDTH-1:0] r_a_id;
  logic [DATA_WIDTH-1:0] r_a_data;
  logic                  r_l_full;
  logic [GPRS_WIDTH-1:0] r_l_id;
  logic [DATA_WIDTH-1:0] r_l_data;

  // Last granted source; reset to L so A wins the first tie.
  src_e r_ptr;

  // Output register
  logic                  r_wr_en;
  logic [GPRS_WIDTH-1:0] r_wr_id;
  logic [DATA_WIDTH-1:0] r_wr_data;
  src_e                  r_wr_src;
  logic                  r_commit;

  logic                  w_gnt_a;
  logic                  w_gnt_l;
  logic                  w_gnt_any;
  logic                  w_acc_a;
  logic                  w_acc_l;
  logic [GPRS_WIDTH-1:0] w_sel_id;
  logic [DATA_WIDTH-1:0] w_sel_data;
  src_e                  w_sel_src;

  // Grant looks only at registered slot state, keeping valid->ready free of
  // combinational paths. A flush cycle issues no grant.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_l = 1'b0;
    if (!i_flush) begin
      case ({r_a_full, r_l_full})
        2'b10:   w_gnt_a = 1'b1;
        2'b01:   w_gnt_l = 1'b1;
        2'b11: begin
          if (r_ptr == SRC_L) w_gnt_a = 1'b1;
          else                w_gnt_l = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_gnt_any  = w_gnt_a | w_gnt_l;
  assign w_sel_id   = w_gnt_l ? r_l_id   : r_a_id;
  assign w_sel_data = w_gnt_l ? r_l_data : r_a_data;
  assign w_sel_src  = w_gnt_l ? SRC_L    : SRC_A;

  assign o_alu_ready = !i_flush && (!r_a_full || w_gnt_a);
  assign o_lsu_ready = !i_flush && (!r_l_full || w_gnt_l);
  assign w_acc_a     = i_alu_valid && o_alu_ready;
  assign w_acc_l     = i_lsu_valid && o_lsu_ready;

  // A refill in the grant cycle replaces the entry and keeps the slot full.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_full <= 1'b0;
      r_a_id   <= '0;
      r_a_data <= '0;
    end else if (i_flush) begin
      r_a_full <= 1'b0;
    end else if (w_acc_a) begin
      r_a_full <= 1'b1;
      r_a_id   <= i_alu_id;
      r_a_data <= i_alu_data;
    end else if (w_gnt_a) begin
      r_a_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_l_full <= 1'b0;
      r_l_id   <= '0;
      r_l_data <= '0;
    end else if (i_flush) begin
      r_l_full <= 1'b0;
    end else if (w_acc_l) begin
      r_l_full <= 1'b1;
      r_l_id   <= i_lsu_id;
      r_l_data <= i_lsu_data;
    end else if (w_gnt_l) begin
      r_l_full <= 1'b0;
    end
  end

  // Flush suppresses grants, so the pointer naturally holds through it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= SRC_L;
    end else if (w_gnt_any) begin
      r_ptr <= w_sel_src;
    end
  end

  // x0 targets still retire (commit) but never strobe the register file.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_id   <= '0;
      r_wr_data <= '0;
      r_wr_src  <= SRC_A;
      r_commit  <= 1'b0;
    end else begin
      r_commit  <= w_gnt_any;
      r_wr_en   <= w_gnt_any && (w_sel_id != '0);
      r_wr_id   <= w_gnt_any ? w_sel_id   : '0;
      r_wr_data <= w_gnt_any ? w_sel_data : '0;
      if (w_gnt_any) r_wr_src <= w_sel_src;
    end
  end

  assign o_gpr_wr_en   = r_wr_en;
  assign o_gpr_wr_id   = r_wr_id;
  assign o_gpr_wr_data = r_wr_data;
  assign o_wr_src      = r_wr_src;
  assign o_commit      = r_commit;
  assign o_busy        = r_a_full || r_l_full || r_commit;

  a_one_hot_grant : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_gnt_a && w_gnt_l));
  a_en_implies_commit : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_wr_en |-> r_commit);

endmodule

// File: doc/gpr_wr_arb.md
Name: gpr_wr_arb

Overview:
- Shares the single GPR write port between two result producers:
  - the ALU/PC path (requester A),
  - the load path (requester L).
- Each requester hands off through a valid/ready handshake into a one-entry holding slot.
- A round-robin arbiter drains the slots into a registered write port that feeds the GPR file, with a retire pulse for PC/commit tracking.
- Sits between EXU/LSU and the register file, replacing the always-ready combinational writeback path.

Parameters:
- DATA_WIDTH, 32, width of write data.
- GPRS_WIDTH, 5, width of GPR index.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_alu_valid  input  1  requester A has a result.
- o_alu_ready  output  1  requester A slot can accept.
- i_alu_id  input  GPRS_WIDTH  destination register, A.
- i_alu_data  input  DATA_WIDTH  write data, A (ALU result or PC+4, selected upstream).
- i_lsu_valid  input  1  requester L has a result.
- o_lsu_ready  output  1  requester L slot can accept.
- i_lsu_id  input  GPRS_WIDTH  destination register, L.
- i_lsu_data  input  DATA_WIDTH  write data, L.
- i_flush  input  1  discard all pending writes.
- o_gpr_wr_en  output  1  GPR write strobe.
- o_gpr_wr_id  output  GPRS_WIDTH  GPR write index.
- o_gpr_wr_data  output  DATA_WIDTH  GPR write data.
- o_wr_src  output  1  source of current output: 0 = A, 1 = L.
- o_commit  output  1  one-cycle retire pulse per granted entry, including x0 targets.
- o_busy  output  1  either slot full or output register valid.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is synchronous and active-low (i_rst_n); polarity and synchronicity are fixed.
- Reset values:
  - both slots empty; id/data cleared to 0;
  - o_gpr_wr_en=0, o_gpr_wr_id=0, o_gpr_wr_data=0, o_wr_src=0, o_commit=0;
  - RR pointer = 1 (last grant = L), so A wins the first tie.
- Slot state: per requester {full, id, data}.
  - Accept when valid && ready; the slot loads at that edge.
  - If the slot is being granted in the same cycle, the new entry replaces the old one; full stays 1.
- Ready:
  - ready_x = !i_flush && (!full_x || grant_x).
  - grant depends only on registered slot state, so there is no combinational valid->ready path.
- Arbitration, each cycle, from slot state only:
  - Only A full -> grant A. Only L full -> grant L.
  - Both full -> grant the requester not equal to the pointer.
  - Neither full -> no grant.
  - The pointer updates to the granted source on every grant; otherwise it holds.
- Granted slot clears at the edge unless it is refilled in the same cycle.
- Output register, loaded every edge:
  - o_commit = grant_any;
  - o_gpr_wr_en = grant_any && (granted id != 0);
  - o_gpr_wr_id and o_gpr_wr_data = granted slot contents when grant_any, else 0;
  - o_wr_src = granted source when grant_any, else holds.
  - Outputs are registered and valid for exactly one cycle per grant.
- Latency:
  - handshake at edge N -> slot full after N -> grant during cycle N+1 -> o_gpr_wr_en/o_commit high in cycle after edge N+1;
  - total 2 cycles from handshake to write strobe.
- Throughput:
  - a single requester sustains 1 write/cycle;
  - under contention each requester gets 1 write per 2 cycles, alternating.
- x0 targets: the entry is consumed and o_commit=1, but o_gpr_wr_en=0 and o_gpr_wr_id=0.
- Flush (synchronous, priority over everything except reset):
  - both slots cleared at the edge; no grant is issued in the flush cycle;
  - output register loads en=0, commit=0, id=0, data=0;
  - both readies forced 0 during the flush cycle, so no handshake occurs;
  - pointer is held.
- Reset asserted mid-operation: all pending entries are dropped with no write strobe; state returns to reset values at the next edge.
- Data width rule: data is passed unmodified; no arithmetic is performed in this block.
- o_busy = full_A || full_L || o_commit.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, o_alu_ready=o_lsu_ready=1, o_busy=0.
- A sends id=5, data=0x1234_5678 at edge N -> cycle after N+1: o_gpr_wr_en=1, id=5, data=0x12345678, o_wr_src=0, o_commit=1. Following cycle en=0.
- A and L valid on the same edge (A: id=3/0xAAAA_AAAA, L: id=4/0xBBBB_BBBB) after reset -> A written first, L on the next cycle.
  - Keep both streaming -> grants alternate A,L,A,L; each ready is high every other cycle.
- A streams 8 back-to-back writes, ids 1..8, L idle -> 8 consecutive write strobes with no bubbles; o_alu_ready held 1.
- L sends id=0, data=0xDEAD_BEEF -> o_commit=1, o_gpr_wr_en=0, o_gpr_wr_id=0.
- Both slots full, assert i_flush for one cycle -> next cycle o_commit=0, o_gpr_wr_en=0, o_busy=0; readies low during flush, high after. A tie after flush goes to the source opposite the held pointer.
